register_file: RTL and testbench
================================

Name: register_file

Overview:
- 8-entry, W-bit general-purpose register file for the multicycle processor datapath.
- Two combinational read ports (Add1→out1, Add2→out2) and one synchronous write port (Add3, in).
- Dedicated link-register write strobe (LRWrite) stores `in` into the link register for branch-and-link.
- Sits between instruction decode (register addresses) and the ALU operand latches.

Parameters:
- W, 32, data width of every register and of in/out1/out2.
- N_REGS, 8, number of registers; fixed at 2**AW.
- AW, 3, address width of Add1/Add2/Add3.
- LR_IDX, 7, index of the link register written by LRWrite.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- WE  input  1  write enable for the register at Add3.
- LRWrite  input  1  write enable for the link register (index LR_IDX).
- Add1  input  AW  read address, port 1.
- Add2  input  AW  read address, port 2.
- Add3  input  AW  write address.
- in  input  W  write data, shared by WE and LRWrite.
- out1  output  W  contents of register Add1 (combinational).
- out2  output  W  contents of register Add2 (combinational).

Behaviour:
- Storage: N_REGS registers of W bits. None is hardwired; R0 is writable.
- Reset:
  - At a rising clk edge with reset==0, all registers clear to 0.
  - Reset has priority over WE and LRWrite.
  - out1/out2 read 0 for any address after the reset edge.
  - Reset asserted mid-sequence discards that cycle's writes.
- Write, at a rising edge with reset==1:
  - WE==1: reg[Add3] <= in.
  - LRWrite==1: reg[LR_IDX] <= in.
  - Both asserted: both targets written with the same `in`. If Add3==LR_IDX, a single write of `in` occurs, with no conflict.
  - Neither asserted: all registers hold.
- Read:
  - out1 = reg[Add1], out2 = reg[Add2]; purely combinational, zero-cycle latency.
  - Add1==Add2 is allowed; both ports show the same value.
- Read-during-write (default build): reads return the pre-edge value during the write cycle. The new value is visible immediately after the rising edge (same cycle it is written, before next negedge).
- Addresses are full-range, with no out-of-range case.
- No X propagation: every register is defined after the first reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If WE==1 and Add3==AddN, outN shows `in` combinationally in the same cycle.
  - If LRWrite==1 and AddN==LR_IDX, outN likewise shows `in`.
  - Forwarding is suppressed while reset==0.
- Undefined: plain combinational reads of stored state only, as above.

Decomposition:
- Package regfile_pkg holds the constants:
  - AW=3, N_REGS=8, LR_IDX=7.
  - Typedef reg_addr_t (logic [AW-1:0]).
- One natural sub-module, regfile_word: a single W-bit register with synchronous active-low clear and load enable.
  - Instantiated N_REGS times via generate.
  - Each instance's load = (WE && Add3==i) || (LRWrite && i==LR_IDX).
- Read muxes and optional bypass logic stay in register_file.

Test Plan:
- Reset: hold reset=0 one edge, then Add1=0, Add2=7 → out1=0x00000000, out2=0x00000000.
- Basic write/read: WE=1, Add3=2, in=0xDEADBEEF for one edge; then Add1=2, Add2=3 → out1=0xDEADBEEF, out2=0x00000000.
- Link write: LRWrite=1, WE=0, Add3=1, in=0x00001234 → reg7=0x00001234, reg1 unchanged (0); read Add1=7, Add2=1 → 0x00001234, 0x00000000.
- Dual write: WE=1, LRWrite=1, Add3=4, in=0xA5A5A5A5 → reg4 and reg7 both 0xA5A5A5A5; write with WE=0, LRWrite=0 and in=0xFFFFFFFF → no register changes.
- Reset priority: reg5=0x11111111, then reset=0 with WE=1, Add3=5, in=0x22222222 → reg5=0, all registers 0.
- Read-during-write: reg3=0x1, then WE=1, Add3=3, in=0x2, Add1=3.
  - Without REGFILE_BYPASS_EN: out1=0x1 before the edge, 0x2 after.
  - With REGFILE_BYPASS_EN: out1=0x2 before the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file slice.
// Optional macro REGFILE_BYPASS_EN (used in register_file) enables write-through forwarding.
package regfile_pkg;

  localparam int AW     = 3;
  localparam int N_REGS = 2 ** AW;
  localparam int LR_IDX = 7;

  typedef logic [AW-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// One W-bit storage word with synchronous active-low clear and load enable.
module regfile_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) word_d = d_i;
  end

  // Clear wins over load so a reset cycle discards any pending write.
  always_ff @(posedge clk) begin
    if (!reset) word_q <= '0;
    else        word_q <= word_d;
  end

  assign q_o = word_q;

endmodule : regfile_word

// File: rtl/register_file.sv
// 8-entry register file: two combinational read ports, one write port plus link-register strobe.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file
  import regfile_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         WE,
  input  logic         LRWrite,
  input  reg_addr_t    Add1,
  input  reg_addr_t    Add2,
  input  reg_addr_t    Add3,
  input  logic [W-1:0] in,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2
);

  logic [W-1:0]      regs_q [N_REGS];
  logic [N_REGS-1:0] load;

  // When Add3 equals LR_IDX both strobes hit the same word with the same data.
  for (genvar i = 0; i < N_REGS; i++) begin : g_word
    assign load[i] = (WE && (Add3 == reg_addr_t'(i))) || (LRWrite && (i == LR_IDX));

    regfile_word #(.W(W)) u_word (
      .clk    (clk),
      .reset  (reset),
      .load_i (load[i]),
      .d_i    (in),
      .q_o    (regs_q[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // Forwarding is gated by reset so a clearing cycle never shows the discarded write.
  always_comb begin
    hit1 = reset && ((WE && (Add3 == Add1)) || (LRWrite && (Add1 == reg_addr_t'(LR_IDX))));
    hit2 = reset && ((WE && (Add3 == Add2)) || (LRWrite && (Add2 == reg_addr_t'(LR_IDX))));
    out1 = hit1 ? in : regs_q[Add1];
    out2 = hit2 ? in : regs_q[Add2];
  end
`else
  always_comb begin
    out1 = regs_q[Add1];
    out2 = regs_q[Add2];
  end
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file; expected read values are queued per driven cycle
// and compared by a negedge monitor. Honours REGFILE_BYPASS_EN for the read-during-write case.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        WE;
  logic        LRWrite;
  logic [2:0]  Add1;
  logic [2:0]  Add2;
  logic [2:0]  Add3;
  logic [31:0] in;
  logic [31:0] out1;
  logic [31:0] out2;

  logic [31:0] exp1Q [$];
  logic [31:0] exp2Q [$];
  string       nameQ [$];

  int testsRun = 0;
  int testsFailed = 0;

  register_file #(.W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .WE      (WE),
    .LRWrite (LRWrite),
    .Add1    (Add1),
    .Add2    (Add2),
    .Add3    (Add3),
    .in      (in),
    .out1    (out1),
    .out2    (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each negedge with a pending expectation compares both read ports.
  always @(negedge clk) begin
    if (exp1Q.size() != 0) begin
      logic [31:0] e1;
      logic [31:0] e2;
      string       nm;
      e1 = exp1Q.pop_front();
      e2 = exp2Q.pop_front();
      nm = nameQ.pop_front();
      checkOutput(nm, e1, e2);
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] e1, input logic [31:0] e2);
    testsRun++;
    if (out1 !== e1 || out2 !== e2) begin
      testsFailed++;
      $display("[TB] FAIL %s: out1=%h out2=%h expected out1=%h out2=%h", nm, out1, out2, e1, e2);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input logic lr,
                               input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3,
                               input logic [31:0] din, input bit chk,
                               input logic [31:0] e1, input logic [31:0] e2, input string nm);
    @(posedge clk);
    #1;
    reset = rst; WE = we; LRWrite = lr;
    Add1 = a1; Add2 = a2; Add3 = a3; in = din;
    if (chk) begin
      exp1Q.push_back(e1);
      exp2Q.push_back(e2);
      nameQ.push_back(nm);
    end
  endtask

  logic [31:0] rdwExp;

  initial begin
    reset = 1'b0; WE = 1'b0; LRWrite = 1'b0;
    Add1 = '0; Add2 = '0; Add3 = '0; in = '0;
`ifdef REGFILE_BYPASS_EN
    rdwExp = 32'h2;
`else
    rdwExp = 32'h1;
`endif

    //            rst we lr a1 a2 a3 din           chk exp1          exp2
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         "none");
    applyStimulus(1, 0, 0, 0, 7, 0, 32'h0,         1, 32'h0,         32'h0,         "reset_clear");
    applyStimulus(1, 1, 0, 0, 1, 2, 32'hDEADBEEF,  1, 32'h0,         32'h0,         "write_r2_pre");
    applyStimulus(1, 0, 0, 2, 3, 0, 32'h0,         1, 32'hDEADBEEF,  32'h0,         "read_r2_r3");
    applyStimulus(1, 0, 1, 1, 6, 1, 32'h00001234,  1, 32'h0,         32'h0,         "lr_write_pre");
    applyStimulus(1, 0, 0, 7, 1, 0, 32'h0,         1, 32'h00001234,  32'h0,         "read_lr_r1");
    applyStimulus(1, 1, 1, 0, 2, 4, 32'hA5A5A5A5,  1, 32'h0,         32'hDEADBEEF,  "dual_write_pre");
    applyStimulus(1, 0, 0, 4, 7, 0, 32'hFFFFFFFF,  1, 32'hA5A5A5A5,  32'hA5A5A5A5,  "dual_result");
    applyStimulus(1, 0, 0, 4, 7, 0, 32'h0,         1, 32'hA5A5A5A5,  32'hA5A5A5A5,  "no_write_hold");
    applyStimulus(1, 0, 0, 2, 1, 0, 32'h0,         1, 32'hDEADBEEF,  32'h0,         "hold_r2_r1");
    applyStimulus(1, 1, 0, 0, 3, 5, 32'h11111111,  1, 32'h0,         32'h0,         "write_r5_pre");
    applyStimulus(0, 1, 0, 5, 7, 5, 32'h22222222,  1, 32'h11111111,  32'hA5A5A5A5,  "reset_cycle_read");
    applyStimulus(1, 0, 0, 5, 7, 0, 32'h0,         1, 32'h0,         32'h0,         "reset_priority");
    applyStimulus(1, 0, 0, 2, 4, 0, 32'h0,         1, 32'h0,         32'h0,         "reset_all_zero");
    applyStimulus(1, 1, 0, 0, 0, 3, 32'h1,         1, 32'h0,         32'h0,         "write_r3_one");
    applyStimulus(1, 1, 0, 3, 3, 3, 32'h2,         1, rdwExp,        rdwExp,        "rdw_before_edge");
    applyStimulus(1, 0, 0, 3, 0, 0, 32'h0,         1, 32'h2,         32'h0,         "rdw_after_edge");
    applyStimulus(1, 1, 1, 6, 6, 7, 32'hCAFEF00D,  1, 32'h0,         32'h0,         "same_target_pre");
    applyStimulus(1, 0, 0, 7, 3, 0, 32'h0,         1, 32'hCAFEF00D,  32'h2,         "same_target_lr");
    applyStimulus(1, 1, 0, 1, 1, 0, 32'h0BADC0DE,  1, 32'h0,         32'h0,         "write_r0_pre");
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0,         1, 32'h0BADC0DE,  32'h0BADC0DE,  "r0_writable");

    repeat (3) @(posedge clk);
    testsRun++;
    if (exp1Q.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected pending=0", exp1Q.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_register_file
